// File: rtl/uart_tx_pkg.sv
// Shared types and line levels for the UART transmitter.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_S,
    DATA_S,
    PARITY_S,
    STOP_S
  } uart_tx_state_t;

  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  // Wide enough to index up to 8 data bits or 2 stop bits.
  localparam int IDX_W = 4;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-time counter: runs 0..CLKS_PER_BIT-1 and restarts on clr or wrap.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick     = (count == LAST);
  // One cycle ahead of tick, so registered outputs can land on the bit_end cycle.
  assign pre_tick = (count == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_send,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_serial,
  output logic                 tx_busy,
  output logic                 tx_stop_s,
  output logic                 tx_done
);

  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  uart_tx_state_t       state, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 armed_q, armed_d;
  logic                 par_q, par_d;
  logic                 tick, pre_tick, clr, start_go;
  logic                 serial_d, busy_d, stop_d, done_d;

  // Handshake: tx_send is a level request; a frame starts only when the
  // request is seen while armed. The request is acknowledged by tx_stop_s
  // (held for the whole stop phase); dropping tx_send for any cycle re-arms.
  assign start_go = (state == IDLE) && tx_send && armed_q;
  assign clr      = (state_d != state);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_q   <= '0;
      idx_q     <= '0;
      armed_q   <= 1'b1;
      par_q     <= 1'b0;
      tx_serial <= UART_IDLE_LVL;
      tx_busy   <= 1'b0;
      tx_stop_s <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state     <= state_d;
      shift_q   <= shift_d;
      idx_q     <= idx_d;
      armed_q   <= armed_d;
      par_q     <= par_d;
      tx_serial <= serial_d;
      tx_busy   <= busy_d;
      tx_stop_s <= stop_d;
      tx_done   <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (start_go) state_d = START_S;
      START_S:  if (tick) state_d = DATA_S;
      DATA_S:   if (tick && idx_q == LAST_DATA) state_d = (PARITY_EN != 0) ? PARITY_S : STOP_S;
      PARITY_S: if (tick) state_d = STOP_S;
      STOP_S:   if (tick && idx_q == LAST_STOP) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    par_d   = par_q;
    armed_d = armed_q;
    idx_d   = idx_q;
    if (start_go) begin
      shift_d = tx_data;
      par_d   = (^tx_data) ^ (PARITY_ODD != 0);
      armed_d = 1'b0;
    end
    if (!tx_send) armed_d = 1'b1;
    if (state == DATA_S && tick) shift_d = shift_q >> 1;
    if (clr) begin
      idx_d = '0;
    end else if ((state == DATA_S || state == STOP_S) && tick) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  // Outputs are computed from the next-cycle state so they register with it.
  always_comb begin
    serial_d = UART_IDLE_LVL;
    case (state_d)
      START_S:  serial_d = UART_START_LVL;
      DATA_S:   serial_d = shift_d[0];
      PARITY_S: serial_d = par_d;
      default:  serial_d = UART_IDLE_LVL;
    endcase
    busy_d = (state_d != IDLE);
    stop_d = (state_d == STOP_S);
    done_d = (state == STOP_S) && (state_d == STOP_S) && pre_tick && (idx_q == LAST_STOP);
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CLKS_PER_BIT=4: plain, even-parity and odd-parity instances.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       tx_send;
  logic [7:0] tx_data;
  logic [2:0] ser, busy, stop_s, done;

  logic [0:0] exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut (
    .clk(clk), .rst(rst), .tx_send(tx_send), .tx_data(tx_data),
    .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_stop_s(stop_s[0]), .tx_done(done[0])
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_par_even (
    .clk(clk), .rst(rst), .tx_send(tx_send), .tx_data(tx_data),
    .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_stop_s(stop_s[1]), .tx_done(done[1])
  );

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_par_odd (
    .clk(clk), .rst(rst), .tx_send(tx_send), .tx_data(tx_data),
    .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_stop_s(stop_s[2]), .tx_done(done[2])
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // driver: push the expected line levels of one frame, one entry per bit time
  task automatic push_frame(input logic [7:0] d, input int par_en, input logic odd);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (par_en != 0) exp_q.push_back((^d) ^ odd);
    exp_q.push_back(1'b1);
  endtask

  task automatic chk_idle(input string tag, input int sel);
    chk({tag, "_idle_serial"}, 32'(ser[sel]), 32'd1);
    chk({tag, "_idle_busy"}, 32'(busy[sel]), 32'd0);
    chk({tag, "_idle_stop"}, 32'(stop_s[sel]), 32'd0);
    chk({tag, "_idle_done"}, 32'(done[sel]), 32'd0);
  endtask

  // scoreboard: call at the negedge where tx_send was just raised
  task automatic check_frame(input string tag, input int sel, input int drop_at,
                             input int data_at, input logic [7:0] data_new);
    int         nbits;
    int         total;
    int         c;
    logic [0:0] e;
    nbits = exp_q.size();
    total = nbits * CPB;
    for (int b = 0; b < nbits; b++) begin
      e = exp_q.pop_front();
      for (int k = 0; k < CPB; k++) begin
        c = b * CPB + k + 1;
        step();
        chk({tag, "_serial"}, 32'(ser[sel]), 32'(e));
        chk({tag, "_busy"}, 32'(busy[sel]), 32'd1);
        chk({tag, "_stop_s"}, 32'(stop_s[sel]), 32'(b == nbits - 1));
        chk({tag, "_done"}, 32'(done[sel]), 32'(c == total));
        if (c == drop_at) tx_send = 1'b0;
        if (c == data_at) tx_data = data_new;
      end
    end
    step();
    chk_idle(tag, sel);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    rst     = 1'b1;
    tx_send = 1'b0;
    tx_data = 8'h00;
    #2 rst = 1'b0;
    #1;
    chk_idle("reset0", 0);
    chk_idle("reset1", 1);
    step();
    step();
    rst = 1'b1;
    step();

    // single-cycle pulse, 0x55
    tx_data = 8'h55;
    tx_send = 1'b1;
    push_frame(8'h55, 0, 1'b0);
    check_frame("pulse55", 0, 1, 0, 8'h00);
    step();

    // held request, 0xA3: one frame, then quiet until re-armed
    tx_data = 8'hA3;
    tx_send = 1'b1;
    push_frame(8'hA3, 0, 1'b0);
    check_frame("held_a3", 0, 0, 0, 8'h00);
    for (int i = 0; i < 120; i++) begin
      step();
      chk("held_quiet_serial", 32'(ser[0]), 32'd1);
      chk("held_quiet_busy", 32'(busy[0]), 32'd0);
    end
    tx_send = 1'b0;
    step();
    tx_send = 1'b1;
    push_frame(8'hA3, 0, 1'b0);
    check_frame("rearm_a3", 0, 0, 0, 8'h00);
    tx_send = 1'b0;
    step();

    // control-unit handshake: drop send once tx_stop_s is observed
    tx_data = 8'h3C;
    tx_send = 1'b1;
    push_frame(8'h3C, 0, 1'b0);
    check_frame("hshake_3c", 0, (10 - 1) * CPB + 1, 0, 8'h00);
    step();
    chk_idle("hshake_after", 0);

    // parity: 0x07 has three ones -> even parity 1, odd parity 0
    do_reset();
    tx_data = 8'h07;
    tx_send = 1'b1;
    push_frame(8'h07, 1, 1'b0);
    check_frame("par_even", 1, 1, 0, 8'h00);
    do_reset();
    tx_data = 8'h07;
    tx_send = 1'b1;
    push_frame(8'h07, 1, 1'b1);
    check_frame("par_odd", 2, 1, 0, 8'h00);

    // async reset in the middle of data bit 3
    do_reset();
    tx_data = 8'h55;
    tx_send = 1'b1;
    step();
    tx_send = 1'b0;
    for (int i = 0; i < 17; i++) step();
    chk("midrst_pre_serial", 32'(ser[0]), 32'd0);
    chk("midrst_pre_busy", 32'(busy[0]), 32'd1);
    rst = 1'b0;
    #1;
    chk_idle("midrst", 0);
    step();
    tx_data = 8'h96;
    tx_send = 1'b1;
    rst     = 1'b1;
    push_frame(8'h96, 0, 1'b0);
    check_frame("post_rst_96", 0, 1, 0, 8'h00);
    step();

    // data changed during START_S is not transmitted
    tx_data = 8'h0F;
    tx_send = 1'b1;
    push_frame(8'h0F, 0, 1'b0);
    check_frame("late_data", 0, 1, 2, 8'hF0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
